// File: rtl/rv_mem_arbiter.sv
// Single-port memory arbiter for the uRV core: shares one bus port between
// instruction fetch and execute-stage data accesses, one transaction at a time.
module rv_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic [ADDR_WIDTH-1:0] im_addr_i,
  input  logic                  im_rd_i,
  output logic [31:0]           im_data_o,
  output logic                  im_valid_o,

  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [31:0]           dm_data_s_i,
  input  logic [3:0]            dm_data_select_i,
  input  logic                  dm_load_i,
  input  logic                  dm_store_i,
  output logic                  dm_ready_o,
  output logic [31:0]           dm_data_l_o,

  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [31:0]           bus_data_o,
  output logic [3:0]            bus_sel_o,
  output logic                  bus_we_o,
  output logic                  bus_cyc_o,
  input  logic                  bus_ack_i,
  input  logic [31:0]           bus_data_i
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;

  typedef enum logic [1:0] {IDLE, DATA, FETCH, DONE} state_t;

  state_t                state_q, state_d;
  logic                  last_data_q, last_data_d;
  logic                  dm_req;
  logic                  grant_data;

  logic [ADDR_WIDTH-1:0] bus_addr_d;
  logic [DATA_W-1:0]     bus_data_d;
  logic [SEL_W-1:0]      bus_sel_d;
  logic                  bus_we_d;
  logic                  bus_cyc_d;
  logic [DATA_W-1:0]     im_data_d;
  logic                  im_valid_d;
  logic [DATA_W-1:0]     dm_data_l_d;
  logic                  dm_ready_d;

  assign dm_req     = dm_load_i | dm_store_i;
  // Data wins contention unless it won the previous contended/uncontended grant.
  assign grant_data = dm_req & ~(im_rd_i & last_data_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_data_q <= 1'b0;
      bus_addr_o  <= '0;
      bus_data_o  <= '0;
      bus_sel_o   <= '0;
      bus_we_o    <= 1'b0;
      bus_cyc_o   <= 1'b0;
      im_data_o   <= '0;
      im_valid_o  <= 1'b0;
      dm_data_l_o <= '0;
      dm_ready_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      bus_addr_o  <= bus_addr_d;
      bus_data_o  <= bus_data_d;
      bus_sel_o   <= bus_sel_d;
      bus_we_o    <= bus_we_d;
      bus_cyc_o   <= bus_cyc_d;
      im_data_o   <= im_data_d;
      im_valid_o  <= im_valid_d;
      dm_data_l_o <= dm_data_l_d;
      dm_ready_o  <= dm_ready_d;
    end
  end

  // Next-state and next-output logic; bus fields hold their value unless updated.
  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    bus_addr_d  = bus_addr_o;
    bus_data_d  = bus_data_o;
    bus_sel_d   = bus_sel_o;
    bus_we_d    = bus_we_o;
    bus_cyc_d   = bus_cyc_o;
    im_data_d   = im_data_o;
    im_valid_d  = 1'b0;
    dm_data_l_d = dm_data_l_o;
    dm_ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d     = DATA;
          last_data_d = 1'b1;
          bus_addr_d  = dm_addr_i;
          bus_data_d  = dm_data_s_i;
          bus_sel_d   = dm_data_select_i;
          bus_we_d    = dm_store_i;
          bus_cyc_d   = 1'b1;
        end else if (im_rd_i) begin
          state_d     = FETCH;
          last_data_d = 1'b0;
          bus_addr_d  = im_addr_i;
          bus_sel_d   = SEL_W'(4'b1111);
          bus_we_d    = 1'b0;
          bus_cyc_d   = 1'b1;
        end
      end
      DATA: begin
        if (bus_ack_i) begin
          state_d     = DONE;
          bus_cyc_d   = 1'b0;
          bus_we_d    = 1'b0;
          dm_data_l_d = bus_data_i;
          dm_ready_d  = 1'b1;
        end
      end
      FETCH: begin
        if (bus_ack_i) begin
          state_d    = DONE;
          bus_cyc_d  = 1'b0;
          bus_we_d   = 1'b0;
          im_data_d  = bus_data_i;
          im_valid_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule
